// File: rtl/alu_feeder_pkg.sv
// alu_feeder_pkg: state encodings and data width shared by the operand sequencer
package alu_feeder_pkg;
  localparam int DW = 8;
  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_ISSUE = 3'd2,
    S_CAP   = 3'd3,
    S_OUT   = 3'd4
  } state_t;
endpackage

// File: rtl/alu_feeder.sv
// alu_feeder: loads an operand pair for the registered AND stage, captures its result and hands it off
module alu_feeder
  import alu_feeder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [DW-1:0]    opa,
  output logic [DW-1:0]    opb,
  input  logic [DW-1:0]    f_in,
  output logic [DW-1:0]    res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] op_count
);
  state_t           r_state;
  state_t           w_next;
  logic             w_din_ready;
  logic             w_res_valid;
  logic [DW-1:0]    r_opa;
  logic [DW-1:0]    r_opb;
  logic [DW-1:0]    r_res;
  logic [CNT_W-1:0] r_cnt;

  // state register
  always_ff @(posedge m_clock or posedge p_reset)
    if (p_reset) r_state <= S_A;
    else         r_state <= w_next;

  // next state; handshake flags depend on state only
  always_comb begin
    w_next      = r_state;
    w_din_ready = (r_state == S_A) || (r_state == S_B);
    w_res_valid = (r_state == S_OUT);
    case (r_state)
      S_A:     w_next = din_valid ? S_B : S_A;
      S_B:     w_next = din_valid ? S_ISSUE : S_B;
      S_ISSUE: w_next = S_CAP;
      S_CAP:   w_next = S_OUT;
      S_OUT:   w_next = res_ready ? S_A : S_OUT;
      default: w_next = S_A;
    endcase
  end

  // operands load on their accept edges, result is captured one cycle after issue
  always_ff @(posedge m_clock or posedge p_reset)
    if (p_reset) begin
      r_opa <= '0;
      r_opb <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == S_A && din_valid) r_opa <= din;
      if (r_state == S_B && din_valid) r_opb <= din;
      if (r_state == S_CAP) r_res <= f_in;
      if (r_state == S_OUT && res_ready) r_cnt <= r_cnt + CNT_W'(1);
    end

  assign din_ready = w_din_ready;
  assign res_valid = w_res_valid;
  assign opa       = r_opa;
  assign opb       = r_opb;
  assign res       = r_res;
  assign op_count  = r_cnt;
endmodule
